// File: rtl/uart_cmd_assembler_pkg.sv
// Shared types for the UART command assembler: command word shape and
// the byte-packing state encoding (state value == bytes already collected).
package uart_cmd_assembler_pkg;

  localparam int CMD_WIDTH = 32;
  localparam int CMD_BYTES = 4;
  localparam int BYTE_IDX_W = $clog2(CMD_BYTES);

  typedef logic [CMD_WIDTH-1:0] cmd_word_t;

  typedef enum logic [BYTE_IDX_W-1:0] {
    S_BYTE0 = 2'd0,
    S_BYTE1 = 2'd1,
    S_BYTE2 = 2'd2,
    S_BYTE3 = 2'd3
  } pack_state_t;

endpackage

// File: rtl/uart_cmd_assembler_if.sv
// Handshake bundle between the UART receiver, the assembler and the
// graphite AXI-stream command port. master = assembler side.
interface uart_cmd_assembler_if;
  import uart_cmd_assembler_pkg::*;

  logic      uart_rd_o;
  logic [7:0] uart_data_i;
  logic      uart_valid_i;
  logic      uart_busy_i;
  logic      cmd_axis_tvalid_o;
  logic      cmd_axis_tready_i;
  cmd_word_t cmd_axis_tdata_o;

  modport master (
    output uart_rd_o, cmd_axis_tvalid_o, cmd_axis_tdata_o,
    input  uart_data_i, uart_valid_i, uart_busy_i, cmd_axis_tready_i
  );

  modport slave (
    input  uart_rd_o, cmd_axis_tvalid_o, cmd_axis_tdata_o,
    output uart_data_i, uart_valid_i, uart_busy_i, cmd_axis_tready_i
  );

endinterface

// File: rtl/uart_cmd_assembler_cmd_fifo.sv
// First-word-fall-through FIFO with a registered output stage. The output
// register counts as one of the DEPTH entries; level includes it.
module cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n_i,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  input  logic                     pop,
  output logic                     empty,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_L    = LW'(1);
  localparam logic [AW-1:0] ONE_A    = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    mem_cnt, level_q;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;

  logic do_pop, out_free, load_mem, load_push, mem_wr;

  assign do_pop    = pop && out_valid;
  assign out_free  = !out_valid || do_pop;
  assign load_mem  = out_free && (mem_cnt != '0);
  // Into an idle output stage the pushed word is registered, never passed through.
  assign load_push = out_free && (mem_cnt == '0) && push;
  assign mem_wr    = push && !load_push;

  assign full     = (level_q == FULL_LVL);
  assign empty    = !out_valid;
  assign pop_data = out_data;
  assign level    = level_q;

  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      level_q   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (mem_wr) wr_ptr <= wr_ptr + ONE_A;

      if (load_mem) begin
        out_data  <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + ONE_A;
        out_valid <= 1'b1;
      end else if (load_push) begin
        out_data  <= push_data;
        out_valid <= 1'b1;
      end else if (do_pop) begin
        out_valid <= 1'b0;
      end

      unique case ({mem_wr, load_mem})
        2'b10:   mem_cnt <= mem_cnt + ONE_L;
        2'b01:   mem_cnt <= mem_cnt - ONE_L;
        default: mem_cnt <= mem_cnt;
      endcase

      unique case ({push, do_pop})
        2'b10:   level_q <= level_q + ONE_L;
        2'b01:   level_q <= level_q - ONE_L;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_assembler.sv
// Packs UART bytes MSB-first into 32-bit commands and queues them for the
// graphite AXI-stream command port; drops a stalled partial word on timeout.
//
// state   | meaning
// S_BYTE0 | no bytes of the current word held
// S_BYTE1 | byte 0 held in [31:24]
// S_BYTE2 | bytes 0..1 held in [31:16]
// S_BYTE3 | bytes 0..2 held in [31:8]; next accept completes and pushes
module uart_cmd_assembler
  import uart_cmd_assembler_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic                          clk,
  input  logic                          reset_n_i,
  uart_cmd_assembler_if.master          bus,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic [BYTE_IDX_W-1:0]         partial_o,
  output logic                          timeout_o
);

  pack_state_t state_q;
  cmd_word_t   shift_q;
  cmd_word_t   push_word;
  logic        cooldown_q, rd_en_q, timeout_q;
  logic        fifo_full, fifo_empty;
  logic        accept, push, pop, idle_hit;

  // rd_en_q keeps the strobe low while reset is held and for the reset-release edge.
  assign bus.uart_rd_o = rd_en_q && !fifo_full && !cooldown_q;
  assign accept    = bus.uart_rd_o && bus.uart_valid_i && !bus.uart_busy_i;
  assign push      = accept && (state_q == S_BYTE3);
  assign push_word = {shift_q[CMD_WIDTH-1:8], bus.uart_data_i};
  assign pop       = bus.cmd_axis_tvalid_o && bus.cmd_axis_tready_i;

  assign bus.cmd_axis_tvalid_o = !fifo_empty;
  assign partial_o = state_q;
  assign timeout_o = timeout_q;

  cmd_fifo #(
    .WIDTH (CMD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .push      (push),
    .push_data (push_word),
    .full      (fifo_full),
    .pop       (pop),
    .empty     (fifo_empty),
    .pop_data  (bus.cmd_axis_tdata_o),
    .level     (level_o)
  );

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam int IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
      localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
      logic [IW-1:0] idle_q;

      // idle_q counts completed idle cycles; the drop lands when it would reach TIMEOUT_CYCLES.
      assign idle_hit = !accept && (state_q != S_BYTE0) && (idle_q == IDLE_LAST);

      always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
          idle_q <= '0;
        end else if (accept || (state_q == S_BYTE0) || idle_hit) begin
          idle_q <= '0;
        end else begin
          idle_q <= idle_q + IW'(1);
        end
      end
    end else begin : g_no_timeout
      assign idle_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_BYTE0;
      shift_q    <= '0;
      cooldown_q <= 1'b0;
      rd_en_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      rd_en_q    <= 1'b1;
      cooldown_q <= accept;
      timeout_q  <= idle_hit;
      if (idle_hit) begin
        state_q <= S_BYTE0;
        shift_q <= '0;
      end else if (accept) begin
        unique case (state_q)
          S_BYTE0: begin
            shift_q <= {bus.uart_data_i, 24'h0};
            state_q <= S_BYTE1;
          end
          S_BYTE1: begin
            shift_q[23:16] <= bus.uart_data_i;
            state_q        <= S_BYTE2;
          end
          S_BYTE2: begin
            shift_q[15:8] <= bus.uart_data_i;
            state_q       <= S_BYTE3;
          end
          S_BYTE3: begin
            shift_q <= '0;
            state_q <= S_BYTE0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed self-checking bench for uart_cmd_assembler (FIFO_DEPTH=8,
// TIMEOUT_CYCLES=100).
module tb_uart_cmd_assembler;
  import uart_cmd_assembler_pkg::*;

  localparam int DEPTH = 8;
  localparam int TMO   = 100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] level;
  logic [1:0] partial;
  logic       timeout;

  int checks   = 0;
  int failures = 0;
  cmd_word_t got_q[$];

  uart_cmd_assembler_if bus();

  uart_cmd_assembler #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .reset_n_i (reset_n),
    .bus       (bus),
    .level_o   (level),
    .partial_o (partial),
    .timeout_o (timeout)
  );

  always #5 clk = ~clk;

  // Transfer monitor: inputs change 1ns after posedge, so the negedge view is stable.
  always @(negedge clk) begin
    if (reset_n && bus.cmd_axis_tvalid_o && bus.cmd_axis_tready_i)
      got_q.push_back(bus.cmd_axis_tdata_o);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.uart_data_i  = b;
    bus.uart_valid_i = 1'b1;
    while (!(bus.uart_rd_o && !bus.uart_busy_i) && n < 50) begin
      tick(1);
      n++;
    end
    chk("send_wait", 32'(n < 50), 32'd1);
    tick(1);
    bus.uart_valid_i = 1'b0;
  endtask

  task automatic send_word(input cmd_word_t w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic wait_words(input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < 200) begin
      tick(1);
      k++;
    end
    chk("word_count", got_q.size(), n);
  endtask

  function automatic cmd_word_t wgen(input int i);
    logic [7:0] x;
    x = 8'(i);
    return {8'h10 + x, 8'h20 + x, 8'h30 + x, 8'h40 + x};
  endfunction

  initial begin
    int pulses;
    int first_k;
    logic [1:0] partial_before;
    int n;

    bus.uart_data_i       = 8'h00;
    bus.uart_valid_i      = 1'b0;
    bus.uart_busy_i       = 1'b0;
    bus.cmd_axis_tready_i = 1'b0;

    // Reset values
    #22;
    chk("rst_rd",      bus.uart_rd_o, 0);
    chk("rst_tvalid",  bus.cmd_axis_tvalid_o, 0);
    chk("rst_tdata",   bus.cmd_axis_tdata_o, 0);
    chk("rst_level",   level, 0);
    chk("rst_partial", partial, 0);
    chk("rst_timeout", timeout, 0);
    reset_n = 1'b1;
    tick(1);
    chk("rd_after_reset", bus.uart_rd_o, 1);

    // DEADBEEF with tready held high
    bus.cmd_axis_tready_i = 1'b1;
    send_byte(8'hDE);
    chk("dead_partial1", partial, 1);
    chk("dead_cool1", bus.uart_rd_o, 0);
    send_byte(8'hAD);
    chk("dead_partial2", partial, 2);
    chk("dead_cool2", bus.uart_rd_o, 0);
    send_byte(8'hBE);
    chk("dead_partial3", partial, 3);
    chk("dead_cool3", bus.uart_rd_o, 0);
    send_byte(8'hEF);
    chk("dead_partial0", partial, 0);
    chk("dead_cool4", bus.uart_rd_o, 0);
    chk("dead_tvalid", bus.cmd_axis_tvalid_o, 1);
    chk("dead_tdata", bus.cmd_axis_tdata_o, 32'hDEADBEEF);
    chk("dead_level", level, 1);
    tick(1);
    chk("dead_tvalid_drop", bus.cmd_axis_tvalid_o, 0);
    chk("dead_level0", level, 0);
    chk("dead_count", got_q.size(), 1);
    chk("dead_word", got_q[0], 32'hDEADBEEF);

    // Back-pressure: 9 words into an 8-deep FIFO
    bus.cmd_axis_tready_i = 1'b0;
    got_q.delete();
    for (int i = 0; i < 8; i++) send_word(wgen(i));
    chk("bp_level8", level, 8);
    chk("bp_tvalid", bus.cmd_axis_tvalid_o, 1);
    chk("bp_head_held", bus.cmd_axis_tdata_o, wgen(0));
    bus.uart_data_i  = 8'h18;
    bus.uart_valid_i = 1'b1;
    tick(10);
    chk("bp_rd_low", bus.uart_rd_o, 0);
    chk("bp_partial", partial, 0);
    chk("bp_level_sat", level, 8);
    chk("bp_none_out", got_q.size(), 0);
    bus.cmd_axis_tready_i = 1'b1;
    send_word(wgen(8));
    wait_words(9);
    for (int i = 0; i < 9; i++) chk($sformatf("bp_word%0d", i), got_q[i], wgen(i));
    tick(2);
    chk("bp_level_end", level, 0);

    // UART busy blocks accept
    got_q.delete();
    bus.uart_busy_i  = 1'b1;
    bus.uart_data_i  = 8'hA1;
    bus.uart_valid_i = 1'b1;
    tick(5);
    chk("busy_partial", partial, 0);
    chk("busy_rd_high", bus.uart_rd_o, 1);
    bus.uart_busy_i = 1'b0;
    tick(1);
    bus.uart_valid_i = 1'b0;
    chk("busy_released", partial, 1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    send_byte(8'hA4);
    wait_words(1);
    chk("busy_word", got_q[0], 32'hA1A2A3A4);

    // Timeout drops a stalled partial word
    got_q.delete();
    send_byte(8'h11);
    send_byte(8'h22);
    chk("tmo_partial2", partial, 2);
    pulses = 0;
    first_k = 0;
    partial_before = 2'd0;
    for (int k = 1; k <= 150; k++) begin
      tick(1);
      if (k == TMO - 1) partial_before = partial;
      if (timeout) begin
        pulses++;
        if (first_k == 0) first_k = k;
      end
    end
    chk("tmo_before", partial_before, 2);
    chk("tmo_delay", first_k, TMO);
    chk("tmo_pulses", pulses, 1);
    chk("tmo_partial0", partial, 0);
    chk("tmo_nothing_out", got_q.size(), 0);
    send_word(32'h01020304);
    wait_words(1);
    chk("tmo_resync_word", got_q[0], 32'h01020304);

    // Simultaneous push and pop at level 3
    bus.cmd_axis_tready_i = 1'b0;
    tick(2);
    got_q.delete();
    send_word(wgen(20));
    send_word(wgen(21));
    send_word(wgen(22));
    chk("pp_level3", level, 3);
    send_byte(8'h10 + 8'd23);
    send_byte(8'h20 + 8'd23);
    send_byte(8'h30 + 8'd23);
    bus.uart_data_i  = 8'h40 + 8'd23;
    bus.uart_valid_i = 1'b1;
    n = 0;
    while (!bus.uart_rd_o && n < 20) begin
      tick(1);
      n++;
    end
    chk("pp_rd_ready", bus.uart_rd_o, 1);
    bus.cmd_axis_tready_i = 1'b1;
    tick(1);
    bus.uart_valid_i      = 1'b0;
    bus.cmd_axis_tready_i = 1'b0;
    chk("pp_level_same", level, 3);
    chk("pp_first_out", got_q[0], wgen(20));
    bus.cmd_axis_tready_i = 1'b1;
    wait_words(4);
    for (int i = 1; i < 4; i++) chk($sformatf("pp_word%0d", i), got_q[i], wgen(20 + i));

    // Asynchronous reset mid-word with two words queued
    bus.cmd_axis_tready_i = 1'b0;
    tick(2);
    got_q.delete();
    send_word(wgen(30));
    send_word(wgen(31));
    send_byte(8'h55);
    chk("ar_level2", level, 2);
    chk("ar_partial1", partial, 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("ar_rd",      bus.uart_rd_o, 0);
    chk("ar_tvalid",  bus.cmd_axis_tvalid_o, 0);
    chk("ar_tdata",   bus.cmd_axis_tdata_o, 0);
    chk("ar_level",   level, 0);
    chk("ar_partial", partial, 0);
    chk("ar_timeout", timeout, 0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    chk("ar_rd_back", bus.uart_rd_o, 1);
    bus.cmd_axis_tready_i = 1'b1;
    send_word(wgen(40));
    wait_words(1);
    chk("ar_word", got_q[0], wgen(40));
    tick(3);
    chk("ar_no_stale", got_q.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
